// File: rtl/nco_pm_dt.sv
`default_nettype none
// ============================================================================
// Module      : nco_pm_dt
// Description : Phase-modulating NCO with glitch-free frequency updates at
//               accumulator wrap, valid/ready phase input, programmable
//               dead-time between complementary gate-drive outputs, and an
//               enable FSM that completes the current carrier cycle before
//               going idle.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_pm_dt #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 16,
  parameter int DEAD_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [ACC_W-1:0]   freqControl,
  input  logic               freqLoad,
  input  logic [PHASE_W-1:0] phaseOffset,
  input  logic               phaseValid,
  output logic               phaseReady,
  input  logic [DEAD_W-1:0]  deadTime,
  output logic               rfOut,
  output logic               rfOutN,
  output logic               running,
  output logic               wrap
);

  localparam int LOW_W = ACC_W - PHASE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     freq_active;
  logic [ACC_W-1:0]     freq_pending;
  logic                 pending;
  logic [PHASE_W-1:0]   phase_reg;
  logic                 sq;
  logic [DEAD_W-1:0]    dt_cnt;
  logic                 wrap_reg;

  logic [ACC_W:0]       sum;
  logic                 carry;
  logic [ACC_W-1:0]     pm;
  logic                 unused_pm_bits;
  logic                 acc_run;
  logic                 keep_running;
  logic                 sq_next;
  logic                 wrap_apply;
  logic                 idle_apply;
  logic                 accept_phase;

  // Accumulator add with carry-out, and phase-modulated accumulator value.
  assign sum            = {1'b0, acc} + {1'b0, freq_active};
  assign carry          = sum[ACC_W];
  assign pm             = acc + {phase_reg, {LOW_W{1'b0}}};
  assign unused_pm_bits = ^pm[ACC_W-2:0];

  assign acc_run      = (state != IDLE);
  assign keep_running = acc_run && (state_next != IDLE);
  assign sq_next      = keep_running ? pm[ACC_W-1] : 1'b0;
  assign wrap_apply   = acc_run && carry;
  assign idle_apply   = (state == IDLE) && pending;
  assign accept_phase = phaseValid && (state != DRAIN);

  // Enable FSM: DRAIN lets the carrier finish its cycle before idling.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable)
          state_next = RUN;
        else if (carry || (freq_active == '0))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Accumulator and wrap pulse; cleared whenever the FSM is (or lands in) IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wrap_apply;
      if (keep_running) acc <= sum[ACC_W-1:0];
      else              acc <= '0;
    end
  end

  // Frequency word: staged in freq_pending, switched in only at a wrap (or
  // straight away while idle) so a carrier period is never truncated.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_active  <= '0;
      freq_pending <= '0;
      pending      <= 1'b0;
    end else if (wrap_apply) begin
      if (freqLoad)     freq_active <= freqControl;
      else if (pending) freq_active <= freq_pending;
      pending <= 1'b0;
    end else begin
      if (idle_apply) freq_active <= freq_pending;
      if (freqLoad) begin
        freq_pending <= freqControl;
        pending      <= 1'b1;
      end else if (idle_apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Phase sample capture on handshake; held until the next transfer.
  always_ff @(posedge clk) begin
    if (rst)               phase_reg <= '0;
    else if (accept_phase) phase_reg <= phaseOffset;
  end

  // Square wave and dead-time counter; any sq edge reloads the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq     <= 1'b0;
      dt_cnt <= '0;
    end else begin
      sq <= sq_next;
      if (!keep_running)
        dt_cnt <= '0;
      else if (sq_next != sq)
        dt_cnt <= deadTime;
      else if (dt_cnt != '0)
        dt_cnt <= dt_cnt - DEAD_W'(1);
    end
  end

  // Outputs are forced low while reset is asserted and in IDLE; the drive
  // pair is gated by the dead-time counter so both can never be high.
  assign rfOut      = !rst && acc_run && (dt_cnt == '0) && sq;
  assign rfOutN     = !rst && acc_run && (dt_cnt == '0) && !sq;
  assign running    = !rst && acc_run;
  assign wrap       = !rst && wrap_reg;
  assign phaseReady = !rst && (state != DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_nco_pm_dt.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_pm_dt
// Description : Self-checking bench for nco_pm_dt: cycle vector table plus
//               directed dead-time and frequency-update sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_pm_dt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] freqControl = '0;
  logic        freqLoad = 1'b0;
  logic [15:0] phaseOffset = '0;
  logic        phaseValid = 1'b0;
  logic        phaseReady;
  logic [3:0]  deadTime = '0;
  logic        rfOut;
  logic        rfOutN;
  logic        running;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] FQ = 32'h4000_0000;
  localparam logic [31:0] FE = 32'h2000_0000;
  localparam logic [31:0] FH = 32'h8000_0000;

  nco_pm_dt #(.ACC_W(32), .PHASE_W(16), .DEAD_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .freqControl (freqControl),
    .freqLoad    (freqLoad),
    .phaseOffset (phaseOffset),
    .phaseValid  (phaseValid),
    .phaseReady  (phaseReady),
    .deadTime    (deadTime),
    .rfOut       (rfOut),
    .rfOutN      (rfOutN),
    .running     (running),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        en;
    logic        fl;
    logic [31:0] fc;
    logic        pv;
    logic [15:0] po;
    logic [3:0]  dt;
    logic        x_rf;
    logic        x_rfn;
    logic        x_run;
    logic        x_wrap;
    logic        x_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic en, input logic fl, input logic [31:0] fc,
                     input logic pv, input logic [15:0] po, input logic [3:0] dt,
                     input logic xrf, input logic xrfn, input logic xrun,
                     input logic xwr, input logic xrdy);
    vec_t v;
    v.r = r; v.en = en; v.fl = fl; v.fc = fc; v.pv = pv; v.po = po; v.dt = dt;
    v.x_rf = xrf; v.x_rfn = xrfn; v.x_run = xrun; v.x_wrap = xwr; v.x_rdy = xrdy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrap(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!wrap && n < maxc);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; freqLoad = 1'b0; phaseValid = 1'b0;
    deadTime = '0; freqControl = '0; phaseOffset = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_freq(input logic [31:0] f);
    freqControl = f; freqLoad = 1'b1;
    step();
    freqLoad = 1'b0;
  endtask

  int n;
  int n2;
  int c_rf, c_rfn, c_low, c_both, c_wrap;

  initial begin
    //   rst en fl fc  pv po      dt   rf rfn run wrap rdy
    add(1, 0, 0, 0,  0, 16'h0,  0,   0, 0, 0, 0, 0);
    add(0, 0, 1, FQ, 0, 16'h0,  0,   0, 0, 0, 0, 1);
    add(0, 0, 0, 0,  0, 16'h0,  0,   0, 0, 0, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 1, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 1, 1);
    // drop enable: drain to the next wrap; phase sample offered while draining
    add(0, 0, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 0);
    add(0, 0, 0, 0,  1, 16'h8000, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 0);
    add(0, 0, 0, 0,  0, 16'h0,  0,   0, 0, 0, 1, 1);
    add(0, 0, 0, 0,  0, 16'h0,  0,   0, 0, 0, 0, 1);
    // restart: unmodulated pattern shows the drained sample was not taken
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    // half-cycle phase offset at steady state: inversion two cycles later
    add(0, 1, 0, 0,  1, 16'h8000, 0, 1, 0, 1, 1, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 1, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    // one cycle of DRAIN, then back to RUN without a phase jump
    add(0, 0, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 0);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 1, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   1, 0, 1, 0, 1);
    // reset mid-RUN, then zero frequency word: no wraps, 1-cycle drain
    add(1, 1, 0, 0,  0, 16'h0,  0,   0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 1, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 1);
    add(0, 0, 0, 0,  0, 16'h0,  0,   0, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0, 16'h0,  0,   0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; enable = tbl[i].en; freqLoad = tbl[i].fl; freqControl = tbl[i].fc;
      phaseValid = tbl[i].pv; phaseOffset = tbl[i].po; deadTime = tbl[i].dt;
      step();
      chk($sformatf("v%0d rfOut", i),      32'(rfOut),      32'(tbl[i].x_rf));
      chk($sformatf("v%0d rfOutN", i),     32'(rfOutN),     32'(tbl[i].x_rfn));
      chk($sformatf("v%0d running", i),    32'(running),    32'(tbl[i].x_run));
      chk($sformatf("v%0d wrap", i),       32'(wrap),       32'(tbl[i].x_wrap));
      chk($sformatf("v%0d phaseReady", i), 32'(phaseReady), 32'(tbl[i].x_rdy));
    end

    // Dead-time 1 at an 8-cycle period.
    do_reset();
    load_freq(FE);
    step();
    deadTime = 4'd1;
    enable = 1'b1;
    repeat (20) step();
    c_rf = 0; c_rfn = 0; c_low = 0; c_both = 0; c_wrap = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rfOut) c_rf++;
      if (rfOutN) c_rfn++;
      if (!rfOut && !rfOutN) c_low++;
      if (rfOut && rfOutN) c_both++;
      if (wrap) c_wrap++;
    end
    chk("dt1 rfOut high cycles", 32'(c_rf), 32'd6);
    chk("dt1 rfOutN high cycles", 32'(c_rfn), 32'd6);
    chk("dt1 both low cycles", 32'(c_low), 32'd4);
    chk("dt1 both high cycles", 32'(c_both), 32'd0);
    chk("dt1 wraps", 32'(c_wrap), 32'd2);

    // Dead-time longer than a half period keeps both outputs low.
    deadTime = 4'd5;
    repeat (12) step();
    c_rf = 0; c_rfn = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rfOut) c_rf++;
      if (rfOutN) c_rfn++;
    end
    chk("dt5 rfOut high cycles", 32'(c_rf), 32'd0);
    chk("dt5 rfOutN high cycles", 32'(c_rfn), 32'd0);
    chk("dt5 running", 32'(running), 32'd1);

    // Frequency update mid-cycle: old period completes, then new period.
    do_reset();
    deadTime = 4'd0;
    load_freq(FQ);
    step();
    enable = 1'b1;
    wait_wrap(40, n);
    chk("first wrap latency", 32'(n), 32'd5);
    wait_wrap(40, n);
    chk("steady period", 32'(n), 32'd4);
    step();
    freqControl = FE; freqLoad = 1'b1;
    step();
    freqLoad = 1'b0;
    wait_wrap(40, n2);
    chk("old period completes", 32'(n2 + 2), 32'd4);
    wait_wrap(40, n);
    chk("new period after load", 32'(n), 32'd8);

    // Load exactly on the wrap cycle: new period starts immediately.
    repeat (7) step();
    freqControl = FQ; freqLoad = 1'b1;
    step();
    freqLoad = 1'b0;
    chk("wrap on load cycle", 32'(wrap), 32'd1);
    wait_wrap(40, n);
    chk("period after wrap-cycle load", 32'(n), 32'd4);

    // Two loads before a wrap: the second one wins.
    step();
    freqControl = FE; freqLoad = 1'b1;
    step();
    freqControl = FH;
    step();
    freqLoad = 1'b0;
    wait_wrap(40, n);
    chk("wrap after double load", 32'(n), 32'd1);
    wait_wrap(40, n);
    chk("period after double load", 32'(n), 32'd2);
    chk("running after updates", 32'(running), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
